// File: rtl/seq_detect_param.sv
// ============================================================================
// seq_detect_param : programmable Moore sequence detector with match counter
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_detect_param #(
  parameter int                  PAT_LEN  = 4,
  parameter int                  CNT_W    = 8,
  parameter logic [PAT_LEN-1:0]  PAT_INIT = {PAT_LEN{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w,
  input  logic               valid,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic               count_clr,
  output logic               z,
  output logic [CNT_W-1:0]   count
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] C_FULL    = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] pat_q;
  logic               ovl_q;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] w_hist_n;
  logic [FILL_W-1:0]  w_fill_n;
  logic               w_hit;

  always_comb begin
    w_hist_n = {hist_q[PAT_LEN-2:0], w};
    w_fill_n = (fill_q == C_FULL) ? C_FULL : fill_q + 1'b1;
    w_hit    = valid && !cfg_load && (w_fill_n == C_FULL) && (w_hist_n == pat_q);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = 1'b0;
    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (valid) begin
      z_d = w_hit;
      // Non-overlap mode restarts from an empty history after every match
      if (w_hit && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = w_hist_n;
        fill_d = w_fill_n;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (w_hit && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= PAT_INIT;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (cfg_load) begin
        pat_q <= pattern;
        ovl_q <= overlap;
      end
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

  assign z     = z_q;
  assign count = cnt_q;

endmodule

`default_nettype wire

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Moore sequence detector. It is the next generation of the fixed "two successive ones" detector.
- It matches a programmable PAT_LEN-bit pattern on a qualified serial bit stream.
- It supports overlapping and non-overlapping match modes and counts matches with a saturating counter.
- It sits on serial input lines as a pattern or frame-marker monitor feeding control logic.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of the match counter; legal range 1..32.
- PAT_INIT, {PAT_LEN{1'b1}}, pattern loaded at reset.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst  input  1  asynchronous active-high reset.
- w  input  1  serial data bit; sampled only when valid=1.
- valid  input  1  qualifies w; when 0 the detector holds its state.
- cfg_load  input  1  latch pattern and overlap; flushes history.
- pattern  input  PAT_LEN  new pattern. Bit PAT_LEN-1 is the first-received bit; bit 0 is the most recent.
- overlap  input  1  mode select: 1 = overlapping matches, 0 = non-overlapping.
- count_clr  input  1  synchronous clear of the match counter.
- z  output  1  registered match flag (Moore).
- count  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset (asynchronous, rst=1):
  - z=0, count=0, history=0, fill=0.
  - pat_q=PAT_INIT, ovl_q=1.
  - These values hold for as long as rst is high.
  - Reset mid-stream discards all partial history; no match can complete across a reset.
- Internal state:
  - pat_q: latched pattern.
  - ovl_q: latched mode.
  - history: PAT_LEN-bit shift register; the newest bit enters at bit 0.
  - fill: 0..PAT_LEN, the number of valid history bits; saturates at PAT_LEN.
- Priority at each rising edge: cfg_load > valid.
- cfg_load=1:
  - pat_q<=pattern, ovl_q<=overlap, history<=0, fill<=0, z<=0.
  - w is discarded even if valid=1.
  - count is unaffected unless count_clr=1.
- valid=1 and cfg_load=0:
  - Shift: hist_n = {history[PAT_LEN-2:0], w}; fill_n = min(fill+1, PAT_LEN).
  - Match condition: hit = (fill_n==PAT_LEN) && (hist_n==pat_q).
  - z<=hit.
  - On hit with ovl_q=1: history<=hist_n and fill<=PAT_LEN, so the next bit can complete another match.
  - On hit with ovl_q=0: history<=0 and fill<=0; the next match needs PAT_LEN fresh bits.
  - No hit: history<=hist_n, fill<=fill_n.
- valid=0 and cfg_load=0:
  - history and fill hold.
  - z<=0, so z is never high for two cycles from a single bit.
- Latency: z is high for exactly the one clock cycle following the edge that samples the completing bit.
  - Back-to-back completing bits in overlap mode keep z high continuously.
  - With PAT_LEN=2 and PAT_INIT=2'b11 this reproduces the two-successive-ones detector, with z as a registered flag.
- Counter:
  - count_clr=1: count<=0. This wins over a simultaneous hit, so that hit is not counted.
  - Otherwise, on hit, count<=count+1 if count != all-ones; otherwise count holds at all-ones.
  - No wrap-around.
- The pattern input is ignored except on a cfg_load edge. Changing pattern without cfg_load has no effect.
- No combinational path from any input to any output.

Test Plan:
- Reset and defaults: rst pulse mid-stream with PAT_LEN=4 and defaults, then drive w=1,1,1,1,1 with valid=1.
  - Required: z=0 and count=0 during reset.
  - Required: z first rises in the cycle after the 4th bit; with overlap it stays high through the 5th; count=2.
- Overlap mode: cfg_load pattern=4'b1011, overlap=1; stream 1,0,1,1,0,1,1.
  - Required: z pulses after bit 4 and after bit 7; count=2.
- Non-overlap mode: same stream, overlap=0.
  - Required: z pulses only after bit 4; count=1.
  - Additional stream 1,0,1,1,0,1,1,0,1,1 must give exactly 2 further pulses.
- Valid gaps and config priority: stream 1,0,1,1 with valid=0 inserted between every bit.
  - Required: one z pulse; history held across gaps.
  - Then cfg_load and valid=1 asserted together with w=1, followed by 0,1,1: no match.
  - Required: a match only after 4 new post-load bits.
- Counter: CNT_W=2, pattern 11, overlap=1, six 1-bits.
  - Required: count goes 1,2,3,3,3.
  - count_clr asserted together with a hit gives count=0; the next hit gives count=1.
- Reset mid-operation: stream 1,0,1, assert rst for 1 cycle, then send 1.
  - Required: no z pulse; a full 1011 is needed afterwards to assert z.
